lcd_sequencer: RTL
==================

// Module: lcd_sequencer
// PURPOSE
//  Command/character sequencer directly upstream of the LCD write-cycle stage (HD44780, 8-bit, 2x16).
//  Runs the power-up init sequence, then accepts characters over a valid/ready handshake.
//  Keeps the cursor position and inserts DDRAM address commands at line ends.
//  Issues one byte per write as wr_enable + reg_sel + data_out, then waits for wr_finish.
// PARAMETERS
//  POWERUP_MS  20  ticks (1 ms each) idle after reset before the first command
//  CLEAR_MS    2   ticks waited after any 0x01 (clear) completes
//  COLS        16  characters per line; the display holds 2*COLS characters
//  WR_TIMEOUT  15  max ticks from wr_enable to wr_finish before the error state
// PORTS
//  clk_1ms     in   1  1 kHz system tick clock, rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  char_valid  in   1  upstream has a character on char_data
//  char_data   in   8  ASCII/CGROM code to display
//  char_ready  out  1  sequencer accepts char_data this cycle
//  clr_req     in   1  request display clear + cursor home (level, sampled in READY)
//  wr_finish   in   1  one-tick pulse from the write-cycle stage: byte written
//  wr_enable   out  1  one-tick pulse: start a write cycle
//  reg_sel     out  1  0 = command, 1 = data; drives the write stage's reg_sel
//  data_out    out  8  byte for the LCD bus
//  init_done   out  1  high once the init sequence has completed
//  error       out  1  sticky: wr_finish not seen within WR_TIMEOUT
// BEHAVIOUR
//  - Reset (async, any state): st=PWRUP; wr_enable=0, reg_sel=0, data_out=8'h00, init_done=0, error=0,
//    pos=0, delay/timeout counters=0. Reset mid-write abandons the write. The full init re-runs.
//  - All outputs except char_ready are registered. char_ready = (st==READY) & ~clr_req.
//  - Write rule: in an *_ISSUE state, wr_enable=1 for exactly one tick, with reg_sel/data_out set.
//    Next state is the matching *_WAIT. reg_sel/data_out stay stable until wr_finish.
//    No latency is assumed from the write stage.
//  - Any *_WAIT: on wr_finish, go to DELAY (or the next action). The timeout counter increments each tick.
//    At WR_TIMEOUT it goes to ERROR: error=1, wr_enable=0, char_ready=0, held until reset.
//  - States: PWRUP, INIT_ISSUE, INIT_WAIT, DELAY, READY, CHAR_ISSUE, CHAR_WAIT, ADDR_ISSUE, ADDR_WAIT,
//    CLR_ISSUE, CLR_WAIT, ERROR.
//  - PWRUP: count POWERUP_MS ticks, then INIT_ISSUE with idx=0.
//  - Init table (cmd, post-delay ticks), 6 entries: 38h/5, 38h/1, 38h/1, 0Ch/1, 01h/CLEAR_MS, 06h/1.
//    INIT_WAIT -> DELAY(table delay) -> next idx. After idx 5: init_done=1, st=READY.
//  - READY priority: clr_req > char_valid. clr_req -> CLR_ISSUE (01h, RS=0) -> CLR_WAIT -> DELAY(CLEAR_MS).
//    Then pos=0 and READY.
//  - char_valid&char_ready: latch char_data. CHAR_ISSUE (RS=1) -> CHAR_WAIT. On wr_finish pos<=pos+1.
//  - Line wrap after a char write: new pos==COLS -> ADDR_ISSUE 8'hC0.
//    New pos==2*COLS -> pos=0, ADDR_ISSUE 8'h80.
//    Otherwise READY. ADDR_WAIT -> READY (no extra delay).
//  - pos width: $clog2(2*COLS). Its value only ranges 0..2*COLS-1.
//  - Delay counter: 5-bit minimum, wide enough for max(POWERUP_MS, WR_TIMEOUT).
//  - Simultaneous clr_req and char_valid in READY: the clear wins and the char is not consumed.
//  - wr_finish outside a *_WAIT state is ignored.
// STRUCTURE
//  - lcd_defs.vh (shared): command constants CMD_FUNC_8B2L=38h, CMD_DISP_ON=0Ch, CMD_CLEAR=01h,
//    CMD_ENTRY_INC=06h, DDRAM_L1=80h, DDRAM_L2=C0h; state encodings.
//  - Sub-module lcd_init_rom: combinational idx[2:0] -> {cmd[7:0], delay[4:0], last}.
//  - Everything else lives in this file: FSM, counters, pos.
// TESTING
//  1 Reset, no stimulus: no wr_enable for 20 ticks. Then 6 writes 38,38,38,0C,01,06 with RS=0, separated by
//    5/1/1/1/2/1 idle ticks after each wr_finish; then init_done=1.
//  2 After init, send 'A'(41h): exactly one wr_enable with RS=1, data 41h. char_ready low until the
//    write ends. pos=1.
//  3 Send 16 chars: after the 16th wr_finish, a command C0h (RS=0) is written. Send 16 more: a command
//    80h is written and pos wraps to 0.
//  4 clr_req and char_valid in the same READY tick: 01h is written, char_ready stays 0. The char is
//    accepted only after 2 delay ticks; pos=0.
//  5 Bench withholds wr_finish: error=1 exactly 15 ticks after wr_enable, no further writes.
//    Pulse reset_n low mid-write: all outputs 0 and the init re-runs from PWRUP.

Source files
------------

// File: rtl/lcd_sequencer_pkg.sv
// Shared LCD command bytes, sequencer state encoding and a small width helper.
// Pure declarations: no logic, no latency.
package lcd_sequencer_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] DDRAM_L1      = 8'h80;
  localparam logic [7:0] DDRAM_L2      = 8'hC0;

  typedef enum logic [3:0] {
    ST_PWRUP      = 4'd0,
    ST_INIT_ISSUE = 4'd1,
    ST_INIT_WAIT  = 4'd2,
    ST_DELAY      = 4'd3,
    ST_READY      = 4'd4,
    ST_CHAR_ISSUE = 4'd5,
    ST_CHAR_WAIT  = 4'd6,
    ST_ADDR_ISSUE = 4'd7,
    ST_ADDR_WAIT  = 4'd8,
    ST_CLR_ISSUE  = 4'd9,
    ST_CLR_WAIT   = 4'd10,
    ST_ERROR      = 4'd11
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up command table: idx -> {command, post-write delay in ticks, last-entry flag}.
// Combinational, zero latency; no handshake.
module lcd_init_rom
  import lcd_sequencer_pkg::*;
#(
  parameter int CLEAR_MS = 2
) (
  input  logic [2:0] idx,
  output logic [7:0] cmd,
  output logic [4:0] dly,
  output logic       last
);

  always_comb begin
    cmd  = CMD_FUNC_8B2L;
    dly  = 5'd1;
    last = 1'b0;
    case (idx)
      3'd0: dly = 5'd5;
      3'd1, 3'd2: begin end
      3'd3: cmd = CMD_DISP_ON;
      3'd4: begin
        cmd = CMD_CLEAR;
        dly = 5'(CLEAR_MS);
      end
      3'd5: begin
        cmd  = CMD_ENTRY_INC;
        last = 1'b1;
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 init + character sequencer: one registered wr_enable pulse per byte, then waits for wr_finish.
// Upstream is stalled via char_ready except in READY; a stuck write stage parks the block in ERROR.
module lcd_sequencer
  import lcd_sequencer_pkg::*;
#(
  parameter int POWERUP_MS = 20,
  parameter int CLEAR_MS   = 2,
  parameter int COLS       = 16,
  parameter int WR_TIMEOUT = 15
) (
  input  logic       clk_1ms,
  input  logic       reset_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clr_req,
  input  logic       wr_finish,
  output logic       wr_enable,
  output logic       reg_sel,
  output logic [7:0] data_out,
  output logic       init_done,
  output logic       error
);

  localparam int PW = $clog2(2 * COLS);
  localparam int CW = max_int(5, $clog2(max_int(POWERUP_MS, WR_TIMEOUT) + 1));

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic [CW-1:0] dly_q, dly_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [PW:0]   pos_n;
  logic          to_ready_q, to_ready_d;
  logic          wr_enable_q, wr_enable_d;
  logic          reg_sel_q, reg_sel_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          init_done_q, init_done_d;
  logic          error_q, error_d;

  logic [7:0]    rom_cmd;
  logic [4:0]    rom_dly;
  logic          rom_last;
  logic          in_wait;

  lcd_init_rom #(.CLEAR_MS(CLEAR_MS)) u_init_rom (
    .idx  (idx_q),
    .cmd  (rom_cmd),
    .dly  (rom_dly),
    .last (rom_last)
  );

  assign cnt_n   = cnt_q + CW'(1);
  assign pos_n   = {1'b0, pos_q} + (PW+1)'(1);
  assign in_wait = st_q inside {ST_INIT_WAIT, ST_CHAR_WAIT, ST_ADDR_WAIT, ST_CLR_WAIT};

  assign char_ready = (st_q == ST_READY) && !clr_req;
  assign wr_enable  = wr_enable_q;
  assign reg_sel    = reg_sel_q;
  assign data_out   = data_out_q;
  assign init_done  = init_done_q;
  assign error      = error_q;

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    to_ready_d  = to_ready_q;
    reg_sel_d   = reg_sel_q;
    data_out_d  = data_out_q;
    init_done_d = init_done_q;
    error_d     = error_q;

    // cnt counts ticks since wr_enable rose, so the ISSUE tick itself is tick 1
    if (in_wait && !wr_finish) begin
      cnt_d = cnt_n;
      if (cnt_n == CW'(WR_TIMEOUT)) begin
        st_d    = ST_ERROR;
        error_d = 1'b1;
      end
    end else begin
      case (st_q)
        ST_PWRUP: begin
          cnt_d = cnt_n;
          if (cnt_n == CW'(POWERUP_MS)) begin
            st_d       = ST_INIT_ISSUE;
            cnt_d      = '0;
            reg_sel_d  = 1'b0;
            data_out_d = rom_cmd;
          end
        end
        ST_INIT_ISSUE: begin
          st_d  = ST_INIT_WAIT;
          cnt_d = CW'(1);
        end
        ST_CHAR_ISSUE: begin
          st_d  = ST_CHAR_WAIT;
          cnt_d = CW'(1);
        end
        ST_ADDR_ISSUE: begin
          st_d  = ST_ADDR_WAIT;
          cnt_d = CW'(1);
        end
        ST_CLR_ISSUE: begin
          st_d  = ST_CLR_WAIT;
          cnt_d = CW'(1);
        end
        ST_INIT_WAIT: begin
          st_d       = ST_DELAY;
          cnt_d      = '0;
          dly_d      = CW'(rom_dly);
          to_ready_d = rom_last;
          idx_d      = idx_q + 3'd1;
        end
        ST_CLR_WAIT: begin
          st_d       = ST_DELAY;
          cnt_d      = '0;
          dly_d      = CW'(CLEAR_MS);
          to_ready_d = 1'b1;
        end
        ST_DELAY: begin
          cnt_d = cnt_n;
          if (cnt_n == dly_q) begin
            cnt_d = '0;
            if (to_ready_q) begin
              st_d        = ST_READY;
              init_done_d = 1'b1;
              pos_d       = '0;
            end else begin
              st_d       = ST_INIT_ISSUE;
              reg_sel_d  = 1'b0;
              data_out_d = rom_cmd;
            end
          end
        end
        ST_READY: begin
          if (clr_req) begin
            st_d       = ST_CLR_ISSUE;
            reg_sel_d  = 1'b0;
            data_out_d = CMD_CLEAR;
          end else if (char_valid) begin
            st_d       = ST_CHAR_ISSUE;
            reg_sel_d  = 1'b1;
            data_out_d = char_data;
          end
        end
        ST_CHAR_WAIT: begin
          cnt_d = '0;
          if (pos_n == (PW+1)'(COLS)) begin
            st_d       = ST_ADDR_ISSUE;
            pos_d      = pos_n[PW-1:0];
            reg_sel_d  = 1'b0;
            data_out_d = DDRAM_L2;
          end else if (pos_n == (PW+1)'(2 * COLS)) begin
            st_d       = ST_ADDR_ISSUE;
            pos_d      = '0;
            reg_sel_d  = 1'b0;
            data_out_d = DDRAM_L1;
          end else begin
            st_d  = ST_READY;
            pos_d = pos_n[PW-1:0];
          end
        end
        ST_ADDR_WAIT: begin
          st_d  = ST_READY;
          cnt_d = '0;
        end
        default: begin end
      endcase
    end

    wr_enable_d = st_d inside {ST_INIT_ISSUE, ST_CHAR_ISSUE, ST_ADDR_ISSUE, ST_CLR_ISSUE};
  end

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= ST_PWRUP;
      cnt_q       <= '0;
      dly_q       <= '0;
      idx_q       <= '0;
      pos_q       <= '0;
      to_ready_q  <= 1'b0;
      wr_enable_q <= 1'b0;
      reg_sel_q   <= 1'b0;
      data_out_q  <= 8'h00;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      to_ready_q  <= to_ready_d;
      wr_enable_q <= wr_enable_d;
      reg_sel_q   <= reg_sel_d;
      data_out_q  <= data_out_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
    end
  end

endmodule
